decode_issue_unit: RTL and testbench
====================================

# decode_issue_unit

Consumer end of the instruction-fetch interface. Takes the 16-bit word from the synchronous instruction memory and decodes it. Issues ALU work to the external ALU through a start/done handshake and writes results into a 4×16 register file. Returns to fetch the PC-advance enable, the last ALU result used by branch resolution, and a per-instruction completion pulse.

## Interface
- FETCH_LAT, 2: cycles from an `en_pc` pulse until the memory output holds the new instruction (1 PC register + 1 memory read register).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- instr  input  16  instruction word from instruction memory (registered output).
- alu_result  input  16  ALU result, valid when `alu_done`=1.
- alu_done  input  1  one-cycle ALU completion pulse.
- alu_start  output  1  one-cycle ALU request pulse.
- alu_op  output  4  ALU function, held from ISSUE until WB.
- alu_a, alu_b  output  16 each  ALU operands, held from ISSUE until WB.
- en_pc  output  1  one-cycle PC load enable to fetch.
- last_alu_result  output  16  most recent written-back ALU result.
- done  output  1  one-cycle pulse on ALU instruction retire.
- halted  output  1  level; high once HALT retires.

## Operation
- Instruction class `instr[1:0]`:
  - 00 ALU reg-reg: func [15:12], rd [11:10], rs1 [9:8], rs2 [7:6].
  - 01 ALU imm: func [15:12], rd [11:10], rs1 [9:8], imm6 [7:2] zero-extended to 16.
  - 10 branch: cond [3:2], target [11:4]. Fetch resolves the branch against `last_alu_result`; this block only advances the PC.
  - 11 HALT.
- FSM states: WAIT, DECODE, ISSUE, EXEC, WB, BRANCH, HALT.
  - WAIT: counts FETCH_LAT cycles, then goes to DECODE. After reset it counts FETCH_LAT−1 cycles, since the PC is already 0.
  - DECODE: latches `instr` into an internal register, reads rs1/rs2, and selects the next state by class.
  - ISSUE: `alu_start`=1 for this cycle only; operands and op are driven. Goes to EXEC.
  - EXEC: waits for `alu_done`. An `alu_done` in the ISSUE cycle is ignored. No timeout.
  - WB: writes `alu_result` to rd and to `last_alu_result`; `done`=1 and `en_pc`=1. Goes to WAIT.
  - BRANCH: `en_pc`=1, registers unchanged. Goes to WAIT.
  - HALT: `halted`=1 and all pulses 0. Exits only on reset.
- Reserved `func` values are passed through unchanged; the ALU defines them.
- All data paths are 16-bit; no sign extension anywhere.

## Timing
- Reset values:
  - All outputs 0.
  - Register file all 0.
  - FSM in WAIT with counter cleared.
- Reset asserted mid-instruction aborts the instruction: no writeback, no `en_pc`.
- ALU instruction: WAIT(FETCH_LAT) + DECODE + ISSUE + EXEC(k≥1) + WB. With FETCH_LAT=2 and an ALU answering in 1 cycle, that is 6 cycles per instruction.
- Branch: FETCH_LAT + 2 cycles.
- `en_pc` and `done` are high in the same WB cycle and are never high on consecutive cycles.
- rd = rs1 or rs2: the write in WB is visible to the next instruction's DECODE read. There is no bypass; the sequencing already guarantees it.
- `last_alu_result` updates on the WB clock edge and is stable before the following BRANCH state.

## Structure
- Package `isa_pkg` holds:
  - the class enum (ALU_RR, ALU_IMM, BRANCH, HALT);
  - the FSM state enum;
  - field-position localparams;
  - FETCH_LAT default.
- Sub-module `regfile4x16`:
  - 2 asynchronous read ports, 1 synchronous write port;
  - asynchronous reset to zero.

## Test plan
- Reset, then memory word 0 = ALU_IMM func=ADD, rd=1, rs1=0, imm6=5; ALU model returns a+b after 1 cycle.
  - Expect `alu_start` in cycle 3, `alu_a`=0, `alu_b`=5.
  - Expect `done` and `en_pc` together in cycle 5; r1=5; `last_alu_result`=5.
- ALU_RR rd=2, rs1=1, rs2=1 following the above → `alu_a`=`alu_b`=5; r2=10 (back-to-back dependency, no stall beyond the FSM).
- ALU slow: `alu_done` 7 cycles after start → FSM holds EXEC and keeps operands stable; exactly one `en_pc`.
- Branch word 0x0A06 (target 0xA0, cond 01) → one `en_pc`, no `alu_start`, no `done`; `last_alu_result` unchanged.
- HALT word → `halted`=1; no further `en_pc` or `alu_start` for 50 cycles.
- Assert `reset` during EXEC, then return `alu_done` → no register write and no `en_pc`; FSM restarts from WAIT with all outputs 0.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA definitions for the decode/issue unit
//
// Purpose: instruction class and FSM state encodings, instruction field
// positions, the default fetch latency and a small immediate helper.
// Ports: none (package).

package isa_pkg;

  // Cycles from an en_pc pulse until the memory output shows the new word:
  // one PC register plus one memory read register.
  localparam int DEFAULT_FETCH_LAT = 2;

  localparam int DATA_W  = 16;
  localparam int INSTR_W = 16;
  localparam int NREGS   = 4;
  localparam int RADDR_W = 2;

  // Instruction field positions.
  localparam int FUNC_MSB  = 15;
  localparam int FUNC_LSB  = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 10;
  localparam int RS1_MSB   = 9;
  localparam int RS1_LSB   = 8;
  localparam int RS2_MSB   = 7;
  localparam int RS2_LSB   = 6;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 2;
  localparam int CLASS_MSB = 1;
  localparam int CLASS_LSB = 0;

  typedef enum logic [1:0] {
    ALU_RR  = 2'b00,
    ALU_IMM = 2'b01,
    BRANCH  = 2'b10,
    HALT    = 2'b11
  } instr_class_e;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_BRANCH = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  // The 6-bit immediate is always zero-extended; the ISA has no signed data.
  function automatic logic [DATA_W-1:0] zext_imm6(input logic [5:0] imm);
    return {{(DATA_W-6){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/regfile4x16.sv
// rtl/regfile4x16.sv - 4 x 16 register file, 2 async read ports, 1 sync write port
//
// Purpose: architectural registers r0..r3 for the decode/issue unit.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high, clears every register to 0
//   we             write enable, sampled on clk
//   waddr, wdata   write address and data
//   raddr1/raddr2  combinational read addresses
//   rdata1/rdata2  combinational read data

module regfile4x16
  import isa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [RADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [RADDR_W-1:0] raddr1,
  input  logic [RADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]  rdata1,
  output logic [DATA_W-1:0]  rdata2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // No write-to-read bypass: the sequencer never reads in the cycle it writes.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/decode_issue_unit.sv
// rtl/decode_issue_unit.sv - instruction decode, ALU issue and writeback sequencer
//
// Purpose: consumes the registered instruction-memory word, decodes it,
// issues ALU work through a start/done handshake, writes results into the
// register file and tells fetch when to advance the PC.
// Ports:
//   clk, reset       clock (rising edge) and asynchronous active-high reset
//   instr            instruction word from the registered memory output
//   alu_result       ALU result, valid with alu_done
//   alu_done         one-cycle ALU completion pulse
//   alu_start        one-cycle ALU request pulse
//   alu_op           ALU function, held from ISSUE until WB
//   alu_a, alu_b     ALU operands, held from ISSUE until WB
//   en_pc            one-cycle PC load enable to fetch
//   last_alu_result  most recent written-back ALU result
//   done             one-cycle pulse when an ALU instruction retires
//   halted           level, high once HALT is reached

module decode_issue_unit
  import isa_pkg::*;
#(
  parameter int FETCH_LAT = DEFAULT_FETCH_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_done,
  output logic               alu_start,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               en_pc,
  output logic [DATA_W-1:0]  last_alu_result,
  output logic               done,
  output logic               halted
);

  state_e             state;
  logic [7:0]         wait_cnt;
  logic               first_wait;
  logic [RADDR_W-1:0] ir_rd;

  instr_class_e       cls;
  logic [RADDR_W-1:0] rs1_addr;
  logic [RADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0]  rs1_data;
  logic [DATA_W-1:0]  rs2_data;
  logic               rf_we;
  logic [7:0]         wait_limit;
  logic               wait_over;

  assign cls      = instr_class_e'(instr[CLASS_MSB:CLASS_LSB]);
  assign rs1_addr = instr[RS1_MSB:RS1_LSB];
  assign rs2_addr = instr[RS2_MSB:RS2_LSB];

  // alu_result is only guaranteed valid alongside alu_done, so the register
  // write happens on the edge that accepts it; the value is visible in WB.
  assign rf_we = (state == ST_EXEC) && alu_done;

  // Out of reset the PC is already 0, so one fetch stage is already done.
  assign wait_limit = first_wait ? 8'(FETCH_LAT - 1) : 8'(FETCH_LAT);
  assign wait_over  = (wait_cnt + 8'd1) >= wait_limit;

  regfile4x16 u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (rf_we),
    .waddr  (ir_rd),
    .wdata  (alu_result),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_WAIT;
      wait_cnt        <= '0;
      first_wait      <= 1'b1;
      ir_rd           <= '0;
      alu_start       <= 1'b0;
      alu_op          <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      en_pc           <= 1'b0;
      last_alu_result <= '0;
      done            <= 1'b0;
      halted          <= 1'b0;
    end else begin
      // Pulse outputs default low; the state that owns them raises them.
      alu_start <= 1'b0;
      en_pc     <= 1'b0;
      done      <= 1'b0;

      case (state)
        ST_WAIT: begin
          if (wait_over) begin
            wait_cnt   <= '0;
            first_wait <= 1'b0;
            state      <= ST_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_DECODE: begin
          ir_rd <= instr[RD_MSB:RD_LSB];
          case (cls)
            ALU_RR, ALU_IMM: begin
              alu_op    <= instr[FUNC_MSB:FUNC_LSB];
              alu_a     <= rs1_data;
              alu_b     <= (cls == ALU_IMM) ? zext_imm6(instr[IMM_MSB:IMM_LSB]) : rs2_data;
              alu_start <= 1'b1;
              state     <= ST_ISSUE;
            end
            BRANCH: begin
              // Fetch resolves the branch itself; we only release the PC.
              en_pc <= 1'b1;
              state <= ST_BRANCH;
            end
            HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
          endcase
        end

        // A done pulse seen here belongs to nothing we issued; ignore it.
        ST_ISSUE: state <= ST_EXEC;

        ST_EXEC: begin
          if (alu_done) begin
            last_alu_result <= alu_result;
            done            <= 1'b1;
            en_pc           <= 1'b1;
            state           <= ST_WB;
          end
        end

        ST_WB:     state <= ST_WAIT;
        ST_BRANCH: state <= ST_WAIT;
        ST_HALT:   halted <= 1'b1;
        default:   state <= ST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_issue_unit.sv
// tb/tb_decode_issue_unit.sv - self-checking bench for decode_issue_unit

`timescale 1ns/1ps

module tb_decode_issue_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic [15:0] alu_result = '0;
  logic        alu_done = 1'b0;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, last_alu_result;
  logic        en_pc, done, halted;

  decode_issue_unit #(.FETCH_LAT(2)) dut (
    .clk(clk), .reset(reset), .instr(instr), .alu_result(alu_result),
    .alu_done(alu_done), .alu_start(alu_start), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .en_pc(en_pc),
    .last_alu_result(last_alu_result), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [64];
  int          pc = 0;
  int          alu_lat = 1;
  int          cur_lat = 1;
  bit          rand_lat = 0;
  bit          spur_done = 0;
  int          remaining = 0;
  logic [3:0]  op_q = '0;
  logic [15:0] a_q = '0, b_q = '0;

  typedef struct {
    logic [15:0] word;
    int          lat;
    bit          spur;
    bit          is_alu;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
  } vec_t;

  vec_t tbl [7];
  vec_t rq [$];

  function automatic logic [15:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b + {12'd0, f};
    endcase
  endfunction

  // Fetch (PC reg + registered memory) and ALU models. Values set on the
  // falling edge are the ones the DUT sees on the next rising edge.
  always @(negedge clk) begin
    if (reset) pc = 0;
    instr = mem[pc % 64];
    if (!reset && en_pc) pc = pc + 1;
    alu_done = 1'b0;
    if (!reset && alu_start) begin
      cur_lat   = rand_lat ? int'($urandom_range(1, 4)) : alu_lat;
      remaining = cur_lat;
      op_q = alu_op; a_q = alu_a; b_q = alu_b;
      if (spur_done) begin
        alu_done   = 1'b1;
        alu_result = 16'hDEAD;
      end
    end else if (remaining > 0) begin
      remaining = remaining - 1;
      if (remaining == 0) begin
        alu_done   = 1'b1;
        alu_result = alu_fn(op_q, a_q, b_q);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered at a falling edge; returns at the falling edge after the en_pc cycle.
  task automatic check_instr(input string nm, input vec_t v, input int gap);
    int cyc;
    int ex;
    int unstable;
    logic [15:0] last_before;
    cyc = 0;
    last_before = last_alu_result;
    while (!alu_start && !en_pc && !halted && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " gap"}, 16'(cyc), 16'(gap));
    if (v.is_alu) begin
      chk({nm, " start"}, {15'd0, alu_start}, 16'd1);
      chk({nm, " op"}, {12'd0, alu_op}, {12'd0, v.op});
      chk({nm, " a"}, alu_a, v.a);
      chk({nm, " b"}, alu_b, v.b);
      ex = 0;
      unstable = 0;
      @(negedge clk);
      while (!done && ex < 50) begin
        if (alu_a !== v.a || alu_b !== v.b || alu_op !== v.op || en_pc || alu_start) unstable++;
        ex++;
        @(negedge clk);
      end
      chk({nm, " hold"}, 16'(unstable), 16'd0);
      chk({nm, " exec cycles"}, 16'(ex), 16'(cur_lat));
      chk({nm, " done"}, {15'd0, done}, 16'd1);
      chk({nm, " en_pc"}, {15'd0, en_pc}, 16'd1);
      chk({nm, " last"}, last_alu_result, v.res);
      chk({nm, " wb a"}, alu_a, v.a);
    end else begin
      chk({nm, " br en_pc"}, {15'd0, en_pc}, 16'd1);
      chk({nm, " br start"}, {15'd0, alu_start}, 16'd0);
      chk({nm, " br done"}, {15'd0, done}, 16'd0);
      chk({nm, " br last"}, last_alu_result, last_before);
    end
    @(negedge clk);
    chk({nm, " en_pc next"}, {15'd0, en_pc}, 16'd0);
    chk({nm, " done next"}, {15'd0, done}, 16'd0);
  endtask

  task automatic check_halt(input string nm, input int gap);
    int cyc;
    int pulses;
    cyc = 0;
    while (!halted && cyc < 100) begin
      if (en_pc || alu_start || done) cyc = 200;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " halt gap"}, 16'(cyc), 16'(gap));
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (en_pc || alu_start || done || !halted) pulses++;
    end
    chk({nm, " halt quiet"}, 16'(pulses), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mreg [4];
    logic [15:0] exp_regs [4];
    vec_t v;
    int   c;
    logic [3:0] f;
    logic [1:0] rd, rs1, rs2;
    logic [5:0] imm;

    // ---- Directed program as a table of {word, ALU latency, expectations} ----
    tbl[0] = '{16'h0415, 1, 0, 1, 4'h0, 16'd0,  16'd5,  16'd5};
    tbl[1] = '{16'h0940, 1, 1, 1, 4'h0, 16'd5,  16'd5,  16'd10};
    tbl[2] = '{16'h1E40, 7, 0, 1, 4'h1, 16'd10, 16'd5,  16'd5};
    tbl[3] = '{16'h0A06, 1, 0, 0, 4'h0, 16'd0,  16'd0,  16'd0};
    tbl[4] = '{16'h42FD, 3, 0, 1, 4'h4, 16'd10, 16'd63, 16'h0035};
    tbl[5] = '{16'hF700, 2, 0, 1, 4'hF, 16'd5,  16'h0035, 16'h0049};
    tbl[6] = '{16'h0003, 1, 0, 0, 4'h0, 16'd0,  16'd0,  16'd0};
    exp_regs[0] = 16'h0035; exp_regs[1] = 16'h0049; exp_regs[2] = 16'd10; exp_regs[3] = 16'd5;

    for (int i = 0; i < 64; i++) mem[i] = 16'h0003;
    for (int i = 0; i < 7; i++) mem[i] = tbl[i].word;
    rand_lat = 0;
    do_reset();
    chk("reset alu_start", {15'd0, alu_start}, 16'd0);
    chk("reset en_pc", {15'd0, en_pc}, 16'd0);
    chk("reset done", {15'd0, done}, 16'd0);
    chk("reset halted", {15'd0, halted}, 16'd0);
    chk("reset alu_a", alu_a, 16'd0);
    chk("reset alu_b", alu_b, 16'd0);
    chk("reset alu_op", {12'd0, alu_op}, 16'd0);
    chk("reset last", last_alu_result, 16'd0);
    for (int i = 0; i < 6; i++) begin
      alu_lat = tbl[i].lat;
      spur_done = tbl[i].spur;
      check_instr($sformatf("dir%0d", i), tbl[i], (i == 0) ? 2 : 3);
    end
    spur_done = 0;
    check_halt("dir", 3);
    for (int k = 0; k < 4; k++) chk($sformatf("dir r%0d", k), dut.u_rf.regs[k], exp_regs[k]);

    // ---- Random program checked against an instruction-level model ----
    for (int k = 0; k < 4; k++) mreg[k] = '0;
    rq.delete();
    for (int n = 0; n < 24; n++) begin
      c   = int'($urandom_range(0, 2));
      f   = 4'($urandom);
      rd  = 2'($urandom);
      rs1 = 2'($urandom);
      rs2 = 2'($urandom);
      imm = 6'($urandom);
      if (c == 2) begin
        v = '{(16'($urandom) & 16'hFFFC) | 16'h0002, 1, 0, 0, 4'h0, 16'd0, 16'd0, 16'd0};
      end else begin
        v.word   = (c == 1) ? {f, rd, rs1, imm, 2'b01} : {f, rd, rs1, rs2, 4'($urandom), 2'b00};
        v.lat    = 1;
        v.spur   = 0;
        v.is_alu = 1;
        v.op     = f;
        v.a      = mreg[rs1];
        v.b      = (c == 1) ? {10'd0, imm} : mreg[rs2];
        v.res    = alu_fn(f, v.a, v.b);
        mreg[rd] = v.res;
      end
      rq.push_back(v);
      mem[n] = v.word;
    end
    mem[24] = 16'h0003;
    rand_lat = 1;
    do_reset();
    for (int n = 0; n < 24; n++) check_instr($sformatf("rnd%0d", n), rq[n], (n == 0) ? 2 : 3);
    check_halt("rnd", 3);
    for (int k = 0; k < 4; k++) chk($sformatf("rnd r%0d", k), dut.u_rf.regs[k], mreg[k]);
    rand_lat = 0;

    // ---- Reset during EXEC: the late alu_done must not write back ----
    mem[0] = 16'h0415;
    mem[1] = 16'h0003;
    alu_lat = 3;
    do_reset();
    c = 0;
    while (!alu_start && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("abort start seen", {15'd0, alu_start}, 16'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort reset start", {15'd0, alu_start}, 16'd0);
    chk("abort reset en_pc", {15'd0, en_pc}, 16'd0);
    chk("abort reset a", alu_a, 16'd0);
    chk("abort reset last", last_alu_result, 16'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("abort reset r%0d", k), dut.u_rf.regs[k], 16'd0);
    @(negedge clk);
    @(negedge clk);
    chk("abort no write r1", dut.u_rf.regs[1], 16'd0);
    chk("abort no last", last_alu_result, 16'd0);
    chk("abort restart", {15'd0, alu_start}, 16'd1);
    check_instr("abort rerun", tbl[0], 0);
    check_halt("abort", 3);
    chk("abort final r1", dut.u_rf.regs[1], 16'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
